// File: rtl/cv32e40x_wb_arbiter_if.sv
// Write-back arbiter bus: EX and LSU result offers, flush/clear controls,
// and the arbitrated register-file write port with status.
interface cv32e40x_wb_arbiter_if;
  logic        ex_valid_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        flush_i;
  logic        clr_cnt_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        buf_full_o;
  logic [15:0] stall_cnt_o;

  // Arbiter side
  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  flush_i, clr_cnt_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_full_o, stall_cnt_o
  );

  // Pipeline / driver side
  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output flush_i, clr_cnt_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_full_o, stall_cnt_o
  );
endinterface

// File: rtl/cv32e40x_wb_arbiter.sv
// Shares one register-file write port between EX and LSU. The LSU cannot be
// stalled and always wins; a colliding EX result parks in a one-entry buffer
// that drains in the next LSU-free cycle, keeping EX results in order.
module cv32e40x_wb_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  cv32e40x_wb_arbiter_if.slave  bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   buf_waddr_q, buf_waddr_d;
  logic [DW-1:0]   buf_wdata_q, buf_wdata_d;
  logic            win;
  logic [AW-1:0]   win_waddr;
  logic [DW-1:0]   win_wdata;
  logic            ex_ready;
  logic            ex_acc;
  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic [CW-1:0]   stall_cnt_q;

  // EX may proceed whenever the buffer is free or the LSU is not claiming the port
  assign ex_ready = (state_q == EMPTY) || !bus.lsu_valid_i;
  assign ex_acc   = bus.ex_valid_i && ex_ready;

  // State and holding-buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      buf_waddr_q <= AW'(0);
      buf_wdata_q <= DW'(0);
    end else begin
      state_q     <= state_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

  // Winner selection, buffer capture and next state
  always_comb begin
    state_d     = state_q;
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;
    win         = 1'b0;
    win_waddr   = AW'(0);
    win_wdata   = DW'(0);

    if (bus.lsu_valid_i) begin
      win       = 1'b1;
      win_waddr = bus.lsu_waddr_i;
      win_wdata = bus.lsu_wdata_i;
      if ((state_q == EMPTY) && ex_acc) begin
        buf_waddr_d = bus.ex_waddr_i;
        buf_wdata_d = bus.ex_wdata_i;
        state_d     = FULL;
      end
    end else if (state_q == FULL) begin
      win       = 1'b1;
      win_waddr = buf_waddr_q;
      win_wdata = buf_wdata_q;
      if (ex_acc) begin
        buf_waddr_d = bus.ex_waddr_i;
        buf_wdata_d = bus.ex_wdata_i;
      end else begin
        state_d = EMPTY;
      end
    end else if (ex_acc) begin
      win       = 1'b1;
      win_waddr = bus.ex_waddr_i;
      win_wdata = bus.ex_wdata_i;
    end

    // Flush drops every EX-side result; only an LSU write survives
    if (bus.flush_i) begin
      state_d = EMPTY;
      if (!bus.lsu_valid_i) begin
        win = 1'b0;
      end
    end
  end

  // Registered write port; address/data hold when nothing wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= AW'(0);
      rf_wdata_q <= DW'(0);
    end else begin
      rf_we_q <= win && (win_waddr != AW'(0));
      if (win) begin
        rf_waddr_q <= win_waddr;
        rf_wdata_q <= win_wdata;
      end
    end
  end

  // Saturating count of cycles EX was held off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= CW'(0);
    end else if (bus.clr_cnt_i) begin
      stall_cnt_q <= CW'(0);
    end else if (bus.ex_valid_i && !ex_ready && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

  assign bus.ex_ready_o  = ex_ready;
  assign bus.rf_we_o     = rf_we_q;
  assign bus.rf_waddr_o  = rf_waddr_q;
  assign bus.rf_wdata_o  = rf_wdata_q;
  assign bus.buf_full_o  = (state_q == FULL);
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_cv32e40x_wb_arbiter.sv
// Bench for cv32e40x_wb_arbiter: a queue-based model of the write port
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_cv32e40x_wb_arbiter;

  logic clk;
  logic rst;
  cv32e40x_wb_arbiter_if bus ();

  cv32e40x_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: accepted EX results form an ordered queue; the port takes the
  // LSU if present, otherwise the oldest queued EX result (none on flush).
  logic [36:0] q[$];
  logic        exp_we   = 1'b0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_data = 32'd0;
  logic [15:0] exp_cnt  = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on every clock edge, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_we   = 1'b0;
      exp_addr = 5'd0;
      exp_data = 32'd0;
      exp_cnt  = 16'd0;
    end else begin
      bit          rdy;
      bit          w;
      logic [36:0] e;
      rdy = (q.size() == 0) || !bus.lsu_valid_i;
      if (bus.clr_cnt_i) exp_cnt = 16'd0;
      else if (bus.ex_valid_i && !rdy && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (bus.ex_valid_i && rdy) q.push_back({bus.ex_waddr_i, bus.ex_wdata_i});
      w = 1'b0;
      e = 37'd0;
      if (bus.lsu_valid_i) begin
        w = 1'b1;
        e = {bus.lsu_waddr_i, bus.lsu_wdata_i};
      end else if (!bus.flush_i && q.size() != 0) begin
        w = 1'b1;
        e = q.pop_front();
      end
      if (bus.flush_i) q.delete();
      exp_we = w && (e[36:32] != 5'd0);
      if (w) begin
        exp_addr = e[36:32];
        exp_data = e[31:0];
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rf_we", 32'(bus.rf_we_o), 32'(exp_we));
      chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(exp_addr));
      chk("rf_wdata", bus.rf_wdata_o, exp_data);
      chk("buf_full", 32'(bus.buf_full_o), 32'(q.size() != 0));
      chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(exp_cnt));
      chk("ex_ready", 32'(bus.ex_ready_o), 32'((q.size() == 0) || !bus.lsu_valid_i));
    end
  end

  task automatic drive(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit fl, input bit cc);
    bus.ex_valid_i  = ev;
    bus.ex_waddr_i  = ea;
    bus.ex_wdata_i  = ed;
    bus.lsu_valid_i = lv;
    bus.lsu_waddr_i = la;
    bus.lsu_wdata_i = ld;
    bus.flush_i     = fl;
    bus.clr_cnt_i   = cc;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next falling edge (outputs of the last posedge visible)
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    cmp_en = 1'b1;
    chk("reset_we", 32'(bus.rf_we_o), 32'd0);
    chk("reset_full", 32'(bus.buf_full_o), 32'd0);
    chk("reset_cnt", 32'(bus.stall_cnt_o), 32'd0);
    chk("reset_ready", 32'(bus.ex_ready_o), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // EX only
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("exonly_we", 32'(bus.rf_we_o), 32'd1);
    chk("exonly_addr", 32'(bus.rf_waddr_o), 32'd5);
    chk("exonly_data", bus.rf_wdata_o, 32'h11);
    chk("exonly_full", 32'(bus.buf_full_o), 32'd0);
    tick();

    // Collision: LSU first, buffered EX next
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 1'b0);
    tick();
    idle();
    chk("coll1_addr", 32'(bus.rf_waddr_o), 32'd7);
    chk("coll1_data", bus.rf_wdata_o, 32'hBB);
    chk("coll1_full", 32'(bus.buf_full_o), 32'd1);
    tick();
    chk("coll2_we", 32'(bus.rf_we_o), 32'd1);
    chk("coll2_addr", 32'(bus.rf_waddr_o), 32'd3);
    chk("coll2_data", bus.rf_wdata_o, 32'hAA);
    chk("coll2_full", 32'(bus.buf_full_o), 32'd0);

    // Back-pressure for three LSU cycles while FULL
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd12, 32'h1234, 1'b1, 5'(20 + i), 32'(i), 1'b0, 1'b0);
      #1;
      chk("bp_ready", 32'(bus.ex_ready_o), 32'd0);
      tick();
    end
    chk("bp_cnt", 32'(bus.stall_cnt_o), 32'd3);
    drive(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("drain_addr", 32'(bus.rf_waddr_o), 32'd3);
    chk("drain_data", bus.rf_wdata_o, 32'hAA);
    tick();
    chk("drain2_addr", 32'(bus.rf_waddr_o), 32'd12);
    tick();

    // Flush discards buffered (4,0x55)
    drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd8, 32'h66, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    chk("flush_we", 32'(bus.rf_we_o), 32'd0);
    chk("flush_full", 32'(bus.buf_full_o), 32'd0);
    tick();
    chk("flush_we2", 32'(bus.rf_we_o), 32'd0);
    chk("flush_addr", 32'(bus.rf_waddr_o), 32'd8);

    // x0 destination
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("x0_ready", 32'(bus.ex_ready_o), 32'd1);
    tick();
    idle();
    chk("x0_we", 32'(bus.rf_we_o), 32'd0);
    tick();

    // Saturation: stall until the counter pins at 0xFFFF
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd6, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 5'd10, 32'hC0DE, 1'b1, 5'd9, 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("sat_cnt", 32'(bus.stall_cnt_o), 32'hFFFF);
    chk("sat_full", 32'(bus.buf_full_o), 32'd1);

    // Asynchronous reset while FULL
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.rf_we_o), 32'd0);
    chk("arst_addr", 32'(bus.rf_waddr_o), 32'd0);
    chk("arst_data", bus.rf_wdata_o, 32'd0);
    chk("arst_full", 32'(bus.buf_full_o), 32'd0);
    chk("arst_cnt", 32'(bus.stall_cnt_o), 32'd0);
    chk("arst_ready", 32'(bus.ex_ready_o), 32'd1);
    idle();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 32'(bus.rf_we_o), 32'd0);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
